// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - Samples a multiplexed 7-segment display bus and decodes complete 4-digit frames.
module seg_scan_decoder #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  AN,
   input  logic [7:0]  seg,
   output logic [15:0] value,
   output logic [3:0]  blank_mask,
   output logic [3:0]  dp_mask,
   output logic        valid,
   output logic        err
);
   localparam int            CW         = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX    = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_SAMPLE = CW'(STABLE_CYCLES - 1);

   typedef enum logic {SYNC, COLLECT} state_t;
   state_t state, state_n;

   logic [3:0]    an_q;
   logic [7:0]    seg_q;
   logic [CW-1:0] cnt;
   logic          sample, gap, multi, glyph_ok, blank, dp;
   logic [1:0]    idx;
   logic [3:0]    nib;
   logic [3:0]    seen, seen_n;
   logic [15:0]   sh_val, sh_val_n;
   logic [3:0]    sh_blk, sh_blk_n, sh_dp, sh_dp_n;
   logic          wr, pub, err_n;

   // Stability counter saturates so each dwell yields exactly one sample cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         an_q  <= 4'hF;
         seg_q <= 8'hFF;
         cnt   <= '0;
      end else begin
         an_q  <= AN;
         seg_q <= seg;
         if ({AN, seg} != {an_q, seg_q})
            cnt <= '0;
         else if (cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
      end
   end

   assign sample = (cnt == CNT_SAMPLE);
   assign dp     = ~seg_q[7];

   always_comb begin
      glyph_ok = 1'b1;
      blank    = 1'b0;
      nib      = 4'h0;
      case (~seg_q[6:0])
         7'h3F: nib = 4'h0;
         7'h06: nib = 4'h1;
         7'h5B: nib = 4'h2;
         7'h4F: nib = 4'h3;
         7'h66: nib = 4'h4;
         7'h6D: nib = 4'h5;
         7'h7D: nib = 4'h6;
         7'h07: nib = 4'h7;
         7'h7F: nib = 4'h8;
         7'h6F: nib = 4'h9;
         7'h77: nib = 4'hA;
         7'h7C: nib = 4'hB;
         7'h39: nib = 4'hC;
         7'h5E: nib = 4'hD;
         7'h79: nib = 4'hE;
         7'h71: nib = 4'hF;
         7'h00: blank = 1'b1;
         default: glyph_ok = 1'b0;
      endcase
   end

   always_comb begin
      gap   = 1'b0;
      multi = 1'b0;
      idx   = 2'd0;
      case (an_q)
         4'b1111: gap = 1'b1;
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: multi = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= SYNC;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (sample && !gap && !multi) begin
         if (!glyph_ok)
            state_n = SYNC;
         else if (state == SYNC && idx == 2'd0)
            state_n = COLLECT;
      end
   end

   // Seen is always zero while in SYNC, so the OR also covers the first digit-0 write.
   always_comb begin
      wr     = 1'b0;
      err_n  = 1'b0;
      seen_n = seen;
      if (sample && !gap) begin
         if (multi || !glyph_ok) begin
            err_n  = 1'b1;
            seen_n = 4'h0;
         end else if (state == COLLECT || idx == 2'd0) begin
            wr     = 1'b1;
            seen_n = seen | (4'b0001 << idx);
         end
      end
      pub = wr && (seen_n == 4'hF);
      if (pub)
         seen_n = 4'h0;
      sh_val_n = sh_val;
      sh_blk_n = sh_blk;
      sh_dp_n  = sh_dp;
      if (wr) begin
         sh_val_n[{idx, 2'b00} +: 4] = nib;
         sh_blk_n[idx]               = blank;
         sh_dp_n[idx]                = dp;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seen       <= 4'h0;
         sh_val     <= 16'h0000;
         sh_blk     <= 4'h0;
         sh_dp      <= 4'h0;
         value      <= 16'h0000;
         blank_mask <= 4'h0;
         dp_mask    <= 4'h0;
         valid      <= 1'b0;
         err        <= 1'b0;
      end else begin
         seen   <= seen_n;
         sh_val <= sh_val_n;
         sh_blk <= sh_blk_n;
         sh_dp  <= sh_dp_n;
         valid  <= pub;
         err    <= err_n;
         if (pub) begin
            value      <= sh_val_n;
            blank_mask <= sh_blk_n;
            dp_mask    <= sh_dp_n;
         end
      end
   end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - Scoreboard bench for seg_scan_decoder with a dwell-level reference model.
module tb_seg_scan_decoder;
   localparam int STABLE = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  AN  = 4'hF;
   logic [7:0]  seg = 8'hFF;
   logic [15:0] value;
   logic [3:0]  blank_mask, dp_mask;
   logic        valid, err;

   seg_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
      .clk(clk), .rst(rst), .AN(AN), .seg(seg), .value(value),
      .blank_mask(blank_mask), .dp_mask(dp_mask), .valid(valid), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [6:0] gl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [3:0] multis [4] = '{4'b1100, 4'b0101, 4'b0000, 4'b1010};

   typedef struct {
      bit          is_err;
      logic [15:0] v;
      logic [3:0]  b;
      logic [3:0]  d;
   } ev_t;
   ev_t q[$];

   // Reference model state: frame sync, digits seen, shadow digits, published frame
   bit          synced;
   bit   [3:0]  m_seen;
   logic [3:0]  m_nib [4];
   bit          m_blk [4];
   bit          m_dp  [4];
   logic [15:0] pv;
   logic [3:0]  pb, pd;
   logic [3:0]  last_an  = 4'hF;
   logic [7:0]  last_seg = 8'hFF;

   function automatic void push_ev(bit e);
      ev_t x;
      x.is_err = e; x.v = pv; x.b = pb; x.d = pd;
      q.push_back(x);
   endfunction

   function automatic void model_reset();
      synced = 0; m_seen = 4'h0; pv = 16'h0; pb = 4'h0; pd = 4'h0;
      for (int i = 0; i < 4; i++) begin
         m_nib[i] = 4'h0; m_blk[i] = 0; m_dp[i] = 0;
      end
   endfunction

   function automatic void model_sample(logic [3:0] a, logic [7:0] s);
      int lows = 0;
      int d = 0;
      int n = -1;
      logic [6:0] g;
      g = ~s[6:0];
      if (a == 4'hF) return;
      for (int i = 0; i < 4; i++)
         if (!a[i]) begin lows++; d = i; end
      if (lows > 1) begin push_ev(1); m_seen = 4'h0; return; end
      for (int k = 0; k < 16; k++)
         if (gl[k] == g) n = k;
      if (n < 0 && g != 7'h00) begin push_ev(1); m_seen = 4'h0; synced = 0; return; end
      if (!synced) begin
         if (d != 0) return;
         synced = 1;
      end
      m_nib[d]  = (n < 0) ? 4'h0 : 4'(n);
      m_blk[d]  = (g == 7'h00);
      m_dp[d]   = !s[7];
      m_seen[d] = 1'b1;
      if (m_seen == 4'hF) begin
         pv = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
         pb = {m_blk[3], m_blk[2], m_blk[1], m_blk[0]};
         pd = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
         m_seen = 4'h0;
         push_ev(0);
      end
   endfunction

   function automatic logic [3:0] an_of(int i);
      logic [3:0] m;
      m = 4'b0001 << i;
      return ~m;
   endfunction

   // h >= 16 selects a blank digit
   function automatic logic [7:0] sg(int h, bit dpl);
      logic [6:0] g;
      g = (h > 15) ? 7'h00 : gl[h];
      return {~dpl, ~g};
   endfunction

   // Holds {a,s} for `hold` clock edges; a dwell reaching STABLE edges is one sample.
   task automatic dwell(input logic [3:0] a, input logic [7:0] s, input int hold);
      if ({a, s} == {last_an, last_seg}) begin
         AN = 4'hF; seg = 8'h00;
         @(posedge clk); #1;
      end
      AN = a; seg = s; last_an = a; last_seg = s;
      if (hold >= STABLE) model_sample(a, s);
      repeat (hold) @(posedge clk);
      #1;
   endtask

   task automatic dig(input int i, input int h, input bit dpl, input int hold);
      dwell(an_of(i), sg(h, dpl), hold);
   endtask

   task automatic check_out(input string nm, input logic [15:0] v, input logic [3:0] b, input logic [3:0] d);
      @(negedge clk);
      checks++;
      if (value !== v || blank_mask !== b || dp_mask !== d || valid !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL %s: got value=%h blank=%b dp=%b valid=%b err=%b, required value=%h blank=%b dp=%b valid=0 err=0",
                  nm, value, blank_mask, dp_mask, valid, err, v, b, d);
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      AN = 4'hF; seg = 8'h00;
      @(posedge clk); #1;
      rst = 1'b1; seg = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      check_out("reset_state", 16'h0, 4'h0, 4'h0);
      rst = 1'b0;
      last_an = 4'hF; last_seg = 8'hFF;
      model_reset();
   endtask

   always @(negedge clk) begin
      ev_t x;
      if (valid === 1'b1 || err === 1'b1) begin
         checks++;
         if (valid && err) begin
            errors++;
            $display("FAIL both_pulses: valid=%b err=%b, required at most one", valid, err);
         end else if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: valid=%b err=%b value=%h, required no event", valid, err, value);
         end else begin
            x = q.pop_front();
            if (err !== x.is_err || value !== x.v || blank_mask !== x.b || dp_mask !== x.d) begin
               errors++;
               $display("FAIL event: got err=%b value=%h blank=%b dp=%b, required err=%b value=%h blank=%b dp=%b",
                        err, value, blank_mask, dp_mask, x.is_err, x.v, x.b, x.d);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      int ord [4];
      int r, hold, j, t;
      logic [3:0] a;
      logic [7:0] s;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_out("reset_state", 16'h0, 4'h0, 4'h0);
      rst = 1'b0;

      // Clean 0x1234 frame
      dwell(4'b1110, 8'h99, 8); dwell(4'b1101, 8'hB0, 8);
      dwell(4'b1011, 8'hA4, 8); dwell(4'b0111, 8'hF9, 8);
      check_out("frame_1234", 16'h1234, 4'h0, 4'h0);

      // Short glitch on digit 2 must not be captured
      dig(0, 5, 0, 8); dig(1, 6, 0, 8); dig(2, 9, 0, STABLE - 2);
      dwell(4'hF, 8'hFF, 8); dig(3, 8, 0, 8);
      check_out("glitch_no_publish", 16'h1234, 4'h0, 4'h0);
      dig(2, 7, 0, 8);
      check_out("frame_8765", 16'h8765, 4'h0, 4'h0);

      // Illegal glyph then recovery
      dig(0, 4, 0, 8); dwell(an_of(1), 8'hFE, 8);
      check_out("illegal_glyph_hold", 16'h8765, 4'h0, 4'h0);
      dig(0, 4, 0, 8); dig(1, 3, 0, 8); dig(2, 2, 0, 8); dig(3, 1, 0, 8);
      check_out("recover_1234", 16'h1234, 4'h0, 4'h0);

      // Two digit enables active
      dwell(4'b1100, 8'hF9, 8);
      check_out("multi_an_hold", 16'h1234, 4'h0, 4'h0);

      // Blank digit 2 and dp on digit 0
      dig(0, 13, 1, 8); dig(1, 12, 0, 8); dig(2, 16, 0, 8); dig(3, 10, 0, 8);
      check_out("frame_a0cd", 16'hA0CD, 4'b0100, 4'b0001);

      // Scan starting at digit 2 after reset, then reset mid-frame
      do_reset();
      dig(2, 1, 0, 8); dig(3, 2, 0, 8); dig(0, 3, 0, 8); dig(1, 4, 0, 8);
      check_out("no_sync_yet", 16'h0, 4'h0, 4'h0);
      dig(2, 5, 0, 8); dig(3, 6, 0, 8);
      check_out("frame_6543", 16'h6543, 4'h0, 4'h0);
      dig(0, 7, 0, 8); dig(1, 8, 0, 8);
      do_reset();
      dig(2, 9, 0, 8); dig(3, 10, 0, 8);
      check_out("partial_discarded", 16'h0, 4'h0, 4'h0);
      dig(0, 11, 1, 8); dig(1, 12, 0, 8); dig(2, 14, 1, 8); dig(3, 15, 0, 8);
      check_out("frame_fecb", 16'hFECB, 4'h0, 4'b0101);

      // Randomised scans
      for (int f = 0; f < 80; f++) begin
         for (int k = 0; k < 4; k++) ord[k] = k;
         for (int k = 3; k > 0; k--) begin
            j = $urandom_range(0, k);
            t = ord[k]; ord[k] = ord[j]; ord[j] = t;
         end
         for (int k = 0; k < 4; k++) begin
            r = $urandom_range(0, 99);
            a = (r < 4) ? multis[$urandom_range(0, 3)] : an_of(ord[k]);
            r = $urandom_range(0, 99);
            if (r < 6)       s = 8'($urandom_range(0, 255));
            else if (r < 18) s = sg(16, 1'($urandom_range(0, 1)));
            else             s = sg($urandom_range(0, 15), 1'($urandom_range(0, 1)));
            r = $urandom_range(0, 9);
            hold = (r < 2) ? r + 1 : r + 2;
            if ($urandom_range(0, 19) == 0) dwell(4'hF, 8'hFF, hold);
            dwell(a, s, hold);
         end
         if ($urandom_range(0, 39) == 0) do_reset();
      end

      AN = 4'hF; seg = 8'h00;
      repeat (6) @(posedge clk);
      @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL missing_events: %0d expected events never seen, required 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
